// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC3 memory access controller.
//   state_e : controller sequencing states (idle, address setup, strobe, done)
//   grant_e : which requester currently owns the memory port
//   MEM_DEPTH_DEF : default number of valid memory words
package lc3_mem_pkg;

    localparam int unsigned MEM_DEPTH_DEF = 128;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWrite,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_LD,
        GNT_IF,
        GNT_DM
    } grant_e;

endpackage

// File: rtl/lc3_mem_rr_arbiter.sv
// Grant logic for the memory port: loader has absolute priority, fetch and data
// share the remaining slots round-robin.
//   i_clock, i_reset        : clock, synchronous active-high reset
//   i_ld_req/i_if_req/i_dm_req : raw request lines
//   i_done, i_done_gnt      : a grant is finishing this cycle, and whose it was
//   o_gnt                   : combinational winner (GNT_NONE when nobody asks)
module lc3_mem_rr_arbiter
    import lc3_mem_pkg::*;
(
    input  logic   i_clock,
    input  logic   i_reset,
    input  logic   i_ld_req,
    input  logic   i_if_req,
    input  logic   i_dm_req,
    input  logic   i_done,
    input  grant_e i_done_gnt,
    output grant_e o_gnt
);

    // 1 = data was served last, so fetch wins the next tie.
    logic r_last_dm;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_dm <= 1'b1;
        end else if (i_done) begin
            // Loader completions leave the fetch/data fairness untouched.
            if (i_done_gnt == GNT_IF) begin
                r_last_dm <= 1'b0;
            end else if (i_done_gnt == GNT_DM) begin
                r_last_dm <= 1'b1;
            end
        end
    end

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_ld_req) begin
            o_gnt = GNT_LD;
        end else if (i_if_req && i_dm_req) begin
            o_gnt = r_last_dm ? GNT_IF : GNT_DM;
        end else if (i_if_req) begin
            o_gnt = GNT_IF;
        end else if (i_dm_req) begin
            o_gnt = GNT_DM;
        end
    end

endmodule

// File: rtl/lc3_mem_access_ctrl.sv
// Sequences every access to the level-sensitive LC3 memory. One requester is
// granted at a time; the address is presented for one cycle before any write
// strobe, the strobe is held for ACCESS_CYCLES-1 cycles, then a one-cycle ack
// is pulsed with err.
//   i_clock, i_reset                 : clock, synchronous active-high reset
//   i_ld_*  / o_ld_ack               : program loader (writes via inst path)
//   i_if_*  / o_if_ack, o_if_data    : instruction fetch (reads)
//   i_dm_*  / o_dm_ack, o_dm_rdata   : data access (reads/writes)
//   o_err                            : valid with any ack
//   o_mem_*, i_mem_dout, i_mem_complete : memory pins
module lc3_mem_access_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH     = MEM_DEPTH_DEF,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_ld_req,
    input  logic [15:0] i_ld_addr,
    input  logic [15:0] i_ld_data,
    output logic        o_ld_ack,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic        o_if_ack,
    output logic [15:0] o_if_data,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [15:0] i_dm_addr,
    input  logic [15:0] i_dm_wdata,
    output logic        o_dm_ack,
    output logic [15:0] o_dm_rdata,
    output logic        o_err,
    output logic        o_mem_write_inst,
    output logic [15:0] o_mem_addr_inst,
    output logic [15:0] o_mem_din_inst,
    output logic        o_mem_rd,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_din,
    input  logic [15:0] i_mem_dout,
    input  logic        i_mem_complete
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 2);

    state_e          r_state;
    grant_e          r_gnt;
    logic            r_we;
    logic [CntW-1:0] r_cnt;

    grant_e      w_gnt;
    logic [15:0] w_req_addr;
    logic [15:0] w_req_data;
    logic        w_req_we;
    logic        w_in_range;

    lc3_mem_rr_arbiter u_arb (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_ld_req   (i_ld_req),
        .i_if_req   (i_if_req),
        .i_dm_req   (i_dm_req),
        .i_done     (r_state == StDone),
        .i_done_gnt (r_gnt),
        .o_gnt      (w_gnt)
    );

    always_comb begin
        w_req_addr = '0;
        w_req_data = '0;
        w_req_we   = 1'b0;
        case (w_gnt)
            GNT_LD: begin
                w_req_addr = i_ld_addr;
                w_req_data = i_ld_data;
                w_req_we   = 1'b1;
            end
            GNT_IF: w_req_addr = i_if_addr;
            GNT_DM: begin
                w_req_addr = i_dm_addr;
                w_req_data = i_dm_wdata;
                w_req_we   = i_dm_we;
            end
            default: ;
        endcase
    end

    // Full 16-bit compare; high address bits must never alias into range.
    assign w_in_range = {16'h0000, w_req_addr} < MEM_DEPTH;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state          <= StIdle;
            r_gnt            <= GNT_NONE;
            r_we             <= 1'b0;
            r_cnt            <= '0;
            o_ld_ack         <= 1'b0;
            o_if_ack         <= 1'b0;
            o_dm_ack         <= 1'b0;
            o_err            <= 1'b0;
            o_if_data        <= '0;
            o_dm_rdata       <= '0;
            o_mem_write_inst <= 1'b0;
            o_mem_addr_inst  <= '0;
            o_mem_din_inst   <= '0;
            o_mem_rd         <= 1'b1;
            o_mem_addr       <= '0;
            o_mem_din        <= '0;
        end else begin
            o_ld_ack <= 1'b0;
            o_if_ack <= 1'b0;
            o_dm_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_gnt != GNT_NONE) begin
                        r_gnt <= w_gnt;
                        r_we  <= w_req_we;
                        if (w_in_range) begin
                            r_state <= StSetup;
                            if (w_gnt == GNT_LD) begin
                                o_mem_addr_inst <= w_req_addr;
                                o_mem_din_inst  <= w_req_data;
                            end else begin
                                o_mem_addr <= w_req_addr;
                                o_mem_din  <= w_req_data;
                            end
                        end else begin
                            // Rejected without touching the memory pins.
                            r_state <= StDone;
                            o_err   <= 1'b1;
                            case (w_gnt)
                                GNT_LD: o_ld_ack <= 1'b1;
                                GNT_IF: begin
                                    o_if_ack  <= 1'b1;
                                    o_if_data <= '0;
                                end
                                GNT_DM: begin
                                    o_dm_ack <= 1'b1;
                                    if (!w_req_we) begin
                                        o_dm_rdata <= '0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StSetup: begin
                    r_state          <= StWrite;
                    r_cnt            <= '0;
                    o_mem_write_inst <= (r_gnt == GNT_LD);
                    o_mem_rd         <= !((r_gnt == GNT_DM) && r_we);
                end
                StWrite: begin
                    if (r_cnt == CntLast) begin
                        r_state          <= StDone;
                        o_mem_write_inst <= 1'b0;
                        o_mem_rd         <= 1'b1;
                        case (r_gnt)
                            GNT_LD: begin
                                o_ld_ack <= 1'b1;
                                o_err    <= 1'b0;
                            end
                            GNT_IF: begin
                                o_if_ack  <= 1'b1;
                                o_if_data <= i_mem_dout;
                                o_err     <= !i_mem_complete;
                            end
                            GNT_DM: begin
                                o_dm_ack <= 1'b1;
                                if (!r_we) begin
                                    o_dm_rdata <= i_mem_dout;
                                end
                                o_err <= !i_mem_complete;
                            end
                            default: ;
                        endcase
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    o_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// Directed bench for lc3_mem_access_ctrl with a behavioural 128x16 memory.
module tb_lc3_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_req = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_ack;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_ack;
    logic [15:0] if_data;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic        dm_ack;
    logic [15:0] dm_rdata;
    logic        err;
    logic        mem_write_inst;
    logic [15:0] mem_addr_inst;
    logic [15:0] mem_din_inst;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_complete = 1'b1;

    logic [15:0] mem [0:127];
    int          wr_cnt = 0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lc3_mem_access_ctrl dut (
        .i_clock          (clk),
        .i_reset          (reset),
        .i_ld_req         (ld_req),
        .i_ld_addr        (ld_addr),
        .i_ld_data        (ld_data),
        .o_ld_ack         (ld_ack),
        .i_if_req         (if_req),
        .i_if_addr        (if_addr),
        .o_if_ack         (if_ack),
        .o_if_data        (if_data),
        .i_dm_req         (dm_req),
        .i_dm_we          (dm_we),
        .i_dm_addr        (dm_addr),
        .i_dm_wdata       (dm_wdata),
        .o_dm_ack         (dm_ack),
        .o_dm_rdata       (dm_rdata),
        .o_err            (err),
        .o_mem_write_inst (mem_write_inst),
        .o_mem_addr_inst  (mem_addr_inst),
        .o_mem_din_inst   (mem_din_inst),
        .o_mem_rd         (mem_rd),
        .o_mem_addr       (mem_addr),
        .o_mem_din        (mem_din),
        .i_mem_dout       (mem_dout),
        .i_mem_complete   (mem_complete)
    );

    // Memory model: writes land on the clock edge while a strobe is active.
    always @(posedge clk) begin
        if (mem_write_inst && mem_addr_inst < 16'd128) begin
            mem[mem_addr_inst[6:0]] <= mem_din_inst;
            wr_cnt <= wr_cnt + 1;
        end
        if (!mem_rd && mem_addr < 16'd128) begin
            mem[mem_addr[6:0]] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
    end
    assign mem_dout = mem[mem_addr[6:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access from IDLE; returns ack cycle (-1 on timeout) and per-cycle strobe masks.
    // who: 0 = loader, 1 = fetch, 2 = data.
    task automatic access(input int who, input logic [15:0] addr, input logic [15:0] data,
                          input logic we, output int ack_cyc, output logic aerr,
                          output logic [15:0] rdata, output logic [15:0] wi_mask,
                          output logic [15:0] rdlow_mask);
        logic a;
        ack_cyc = -1;
        aerr = 1'b0;
        rdata = '0;
        wi_mask = '0;
        rdlow_mask = '0;
        case (who)
            0: begin ld_addr = addr; ld_data = data; ld_req = 1'b1; end
            1: begin if_addr = addr; if_req = 1'b1; end
            default: begin dm_addr = addr; dm_wdata = data; dm_we = we; dm_req = 1'b1; end
        endcase
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            wi_mask[k] = mem_write_inst;
            rdlow_mask[k] = !mem_rd;
            a = (who == 0) ? ld_ack : (who == 1) ? if_ack : dm_ack;
            if (a) begin
                ack_cyc = k;
                aerr = err;
                rdata = (who == 1) ? if_data : dm_rdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        ld_req = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    int          ac;
    logic        ae;
    logic [15:0] rd;
    logic [15:0] wim;
    logic [15:0] rlm;
    logic [31:0] if_mask;
    logic [31:0] dm_mask;
    logic [31:0] ld_mask;
    int          wr_before;
    int          bad;

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_rd", 32'(mem_rd), 32'd1);
        check("rst_wi", 32'(mem_write_inst), 32'd0);
        check("rst_acks", {29'd0, ld_ack, if_ack, dm_ack}, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_data", {if_data, dm_rdata}, 32'd0);
        check("rst_addr", {mem_addr, mem_addr_inst}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: loader write then fetch
        access(0, 16'h0005, 16'h1234, 1'b1, ac, ae, rd, wim, rlm);
        check("t1_ld_ack_cyc", 32'(ac), 32'd3);
        check("t1_wi_mask", 32'(wim), 32'h0004);
        check("t1_ld_err", 32'(ae), 32'd0);
        check("t1_mem5", 32'(mem[5]), 32'h1234);
        access(1, 16'h0005, 16'h0000, 1'b0, ac, ae, rd, wim, rlm);
        check("t1_if_ack_cyc", 32'(ac), 32'd3);
        check("t1_if_data", 32'(rd), 32'h1234);
        check("t1_if_err", 32'(ae), 32'd0);
        check("t1_if_rdlow", 32'(rlm), 32'd0);

        // 2: data write/read with neighbours preloaded
        access(0, 16'h000F, 16'h1111, 1'b1, ac, ae, rd, wim, rlm);
        access(0, 16'h0011, 16'h2222, 1'b1, ac, ae, rd, wim, rlm);
        access(2, 16'h0010, 16'hBEEF, 1'b1, ac, ae, rd, wim, rlm);
        check("t2_wr_ack_cyc", 32'(ac), 32'd3);
        check("t2_wr_rdlow", 32'(rlm), 32'h0004);
        check("t2_wr_wi", 32'(wim), 32'd0);
        access(2, 16'h0010, 16'h0000, 1'b0, ac, ae, rd, wim, rlm);
        check("t2_rd_data", 32'(rd), 32'hBEEF);
        check("t2_rd_rdlow", 32'(rlm), 32'd0);
        check("t2_mem0f", 32'(mem[15]), 32'h1111);
        check("t2_mem11", 32'(mem[17]), 32'h2222);

        // 3: fetch/data contention with a loader cutting in
        if_mask = '0;
        dm_mask = '0;
        ld_mask = '0;
        if_addr = 16'h0005;
        dm_addr = 16'h0010;
        dm_we = 1'b0;
        ld_addr = 16'h0020;
        ld_data = 16'h5A5A;
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if_mask[k] = if_ack;
            dm_mask[k] = dm_ack;
            ld_mask[k] = ld_ack;
            if (k == 3) check("t3_if_data", 32'(if_data), 32'h1234);
            if (k == 7) check("t3_dm_data", 32'(dm_rdata), 32'hBEEF);
            @(posedge clk);
            #1;
            if (k + 1 == 9) ld_req = 1'b1;
            if (k + 1 == 16) ld_req = 1'b0;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("t3_if_mask", if_mask, 32'h0000_0808);
        check("t3_dm_mask", dm_mask, 32'h0008_0080);
        check("t3_ld_mask", ld_mask, 32'h0000_8000);
        check("t3_mem20", 32'(mem[32]), 32'h5A5A);

        // 4: out-of-range data read
        wr_before = wr_cnt;
        access(2, 16'h0080, 16'h0000, 1'b0, ac, ae, rd, wim, rlm);
        check("t4_ack_cyc", 32'(ac), 32'd1);
        check("t4_err", 32'(ae), 32'd1);
        check("t4_rdata", 32'(rd), 32'd0);
        check("t4_rdlow", 32'(rlm), 32'd0);
        check("t4_wrcnt", 32'(wr_cnt), 32'(wr_before));
        // Upper address bits must not alias into range.
        access(1, 16'h8005, 16'h0000, 1'b0, ac, ae, rd, wim, rlm);
        check("t4_hi_ack_cyc", 32'(ac), 32'd1);
        check("t4_hi_err", 32'(ae), 32'd1);

        // Memory reporting incomplete sets err on a fetch
        mem_complete = 1'b0;
        access(1, 16'h0005, 16'h0000, 1'b0, ac, ae, rd, wim, rlm);
        mem_complete = 1'b1;
        check("incomplete_err", 32'(ae), 32'd1);

        // 5: reset during WRITE of a data write
        dm_addr = 16'h0012;
        dm_wdata = 16'h7777;
        dm_we = 1'b1;
        dm_req = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_in_write", 32'(mem_rd), 32'd0);
        reset = 1'b1;
        dm_req = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_rd_after_rst", 32'(mem_rd), 32'd1);
        check("t5_no_ack", 32'(dm_ack), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        access(2, 16'h0012, 16'h7777, 1'b1, ac, ae, rd, wim, rlm);
        check("t5_reissue_cyc", 32'(ac), 32'd3);
        check("t5_mem12", 32'(mem[18]), 32'h7777);

        // 6: idle for 20 cycles
        wr_before = wr_cnt;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!mem_rd || mem_write_inst) bad++;
        end
        check("t6_idle_strobes", 32'(bad), 32'd0);
        check("t6_wrcnt", 32'(wr_cnt), 32'(wr_before));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lc3_mem_access_ctrl.md
Name: lc3_mem_access_ctrl

Overview:
- Sequences every access to the 128x16 level-sensitive LC3 memory.
- Arbitrates three requesters onto the single memory port: program loader (writes through the instruction-load path), instruction fetch (reads) and data access (reads/writes).
- Drives the memory's write_inst/addr_inst/din_inst/rd/addr/din pins so no unintended write ever occurs, and returns data with a one-cycle ack pulse.

Parameters:
- MEM_DEPTH, 128, number of valid words; addresses >= MEM_DEPTH are rejected.
- ACCESS_CYCLES, 2, cycles the memory pins are held per access; minimum 2.

Ports:
- clock in 1 system clock, rising edge
- reset in 1 synchronous, active-high
- ld_req in 1 loader request, held until ld_ack
- ld_addr in 16 loader address
- ld_data in 16 loader write data
- ld_ack out 1 one-cycle completion pulse
- if_req in 1 fetch request, held until if_ack
- if_addr in 16 fetch address
- if_ack out 1 one-cycle pulse; if_data valid this cycle
- if_data out 16 fetched word, held until next fetch ack
- dm_req in 1 data request, held until dm_ack
- dm_we in 1 1 = write, 0 = read
- dm_addr in 16 data address
- dm_wdata in 16 data write value
- dm_ack out 1 one-cycle pulse
- dm_rdata out 16 read word, held until next data ack
- err out 1 valid with any ack; 1 = out-of-range address or memory not complete
- mem_write_inst out 1 to memory write_inst
- mem_addr_inst out 16 to memory addr_inst
- mem_din_inst out 16 to memory din_inst
- mem_rd out 1 to memory rd; 0 = write
- mem_addr out 16 to memory addr
- mem_din out 16 to memory din
- mem_dout in 16 from memory dout
- mem_complete in 1 from memory complete

Behaviour:
- Reset: one clock, reset synchronous active-high.
  - State = IDLE.
  - All acks, err, mem_write_inst = 0.
  - mem_rd = 1.
  - mem_addr, mem_din, mem_addr_inst, mem_din_inst, if_data, dm_rdata = 0.
  - Round-robin flag = data-last, so fetch wins first.
- Invariant: mem_rd = 1 in every cycle except write phases of a granted data write. mem_write_inst = 1 only during the write phase of a loader grant.
- FSM states: IDLE, SETUP, WRITE, DONE.
  - IDLE: sample requests. On a grant, latch requester, address, data and we, then go to SETUP.
  - Out-of-range address: skip SETUP/WRITE, go straight to DONE with err = 1. Memory pins untouched; read data returned as 0.
  - SETUP (1 cycle): drive mem_addr/mem_din (or mem_addr_inst/mem_din_inst) with mem_rd = 1 and mem_write_inst = 0, so the address settles before any write strobe.
  - WRITE (ACCESS_CYCLES-1 cycles, counter-timed):
    - Loader: mem_write_inst = 1.
    - Data write: mem_rd = 0.
    - Read: mem_rd = 1.
    - Last cycle: capture mem_dout for reads; capture err = ~mem_complete for fetch/data. Loader err = 0.
  - DONE (1 cycle): pulse the granted ack; present err. Strobes already deasserted. Next state IDLE.
- Latency: req high in IDLE at cycle 0; ack at cycle ACCESS_CYCLES+1 (3 by default); out-of-range ack at cycle 1. The next grant is sampled in the IDLE cycle after DONE.
- Arbitration:
  - ld_req has absolute priority.
  - Between if_req and dm_req: round-robin, winner is the one not served last. The flag updates only on completed fetch/data grants.
  - A lone requester is always granted.
- A request dropped before grant is ignored. Once granted, the access completes and the ack pulses regardless of req.
- Address compare uses the full 16-bit value; upper bits are never truncated.
- Reset mid-access: immediate return to IDLE with strobes deasserted. No ack is issued. Memory word contents for an interrupted write are unspecified.

Decomposition:
- Package lc3_mem_pkg:
  - state encoding (IDLE/SETUP/WRITE/DONE)
  - grant encoding (GNT_NONE, GNT_LD, GNT_IF, GNT_DM)
  - default MEM_DEPTH
- Sub-module lc3_mem_rr_arbiter: priority plus round-robin grant logic and the round-robin flag register.

Test Plan:
1. Loader writes 0x1234 to 0x0005, then fetch of 0x0005 -> ld_ack at cycle 3; mem_write_inst high only in cycle 2; if_ack at cycle 3 of the fetch; if_data = 0x1234; err = 0.
2. Data write 0xBEEF to 0x0010, then data read of 0x0010 -> mem_rd low only in the WRITE cycle; dm_rdata = 0xBEEF; no other word changes (check 0x000F and 0x0011).
3. if_req and dm_req asserted together and held -> grants alternate fetch, data, fetch, data; acks 4 cycles apart. ld_req raised mid-sequence wins the next IDLE.
4. dm_req read at 0x0080 -> dm_ack at cycle 1; err = 1; dm_rdata = 0; mem_rd stays 1; memory untouched.
5. Reset during WRITE of a data write -> next cycle: IDLE, mem_rd = 1, no dm_ack; a re-issued request completes normally.
6. Idle with no requests for 20 cycles -> mem_rd = 1 and mem_write_inst = 0 throughout; memory contents unchanged.
